// File: rtl/fpu_norm_arb.sv
// Round-robin arbiter sharing one fpu_norm between add/sub and mul.
// Optional sticky flags enabled by FPU_NORM_ARB_FLAGS_EN.
module fpu_norm_arb #(
  parameter int C_MANT_PRENORM = 48,
  parameter int C_EXP_PRENORM  = 10,
  parameter int C_MANT         = 23,
  parameter int C_EXP          = 8,
  parameter int C_RM           = 3,
  parameter int C_CMD          = 4
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RI,
  input  logic                      A_Valid_SI,
  output logic                      A_Ready_SO,
  input  logic [C_MANT_PRENORM-1:0] A_Mant_DI,
  input  logic [C_EXP_PRENORM-1:0]  A_Exp_DI,
  input  logic                      A_Sign_DI,
  input  logic [C_RM-1:0]           A_RM_SI,
  input  logic [C_CMD-1:0]          A_OP_SI,
  input  logic                      M_Valid_SI,
  output logic                      M_Ready_SO,
  input  logic [C_MANT_PRENORM-1:0] M_Mant_DI,
  input  logic [C_EXP_PRENORM-1:0]  M_Exp_DI,
  input  logic                      M_Sign_DI,
  input  logic [C_RM-1:0]           M_RM_SI,
  input  logic [C_CMD-1:0]          M_OP_SI,
  output logic [C_MANT_PRENORM-1:0] Norm_Mant_DO,
  output logic [C_EXP_PRENORM-1:0]  Norm_Exp_DO,
  output logic                      Norm_Sign_DO,
  output logic [C_RM-1:0]           Norm_RM_SO,
  output logic [C_CMD-1:0]          Norm_OP_SO,
  input  logic [C_MANT:0]           Norm_Mant_res_DI,
  input  logic [C_EXP-1:0]          Norm_Exp_res_DI,
  input  logic                      Norm_Rounded_SI,
  input  logic                      Norm_OF_SI,
  input  logic                      Norm_UF_SI,
  output logic                      Res_Valid_SO,
  input  logic                      Res_Ready_SI,
  output logic                      Res_Tag_SO,
  output logic [C_MANT:0]           Res_Mant_DO,
  output logic [C_EXP-1:0]          Res_Exp_DO,
  output logic                      Res_Sign_DO,
  output logic                      Res_Rounded_SO,
  output logic                      Res_OF_SO,
  output logic                      Res_UF_SO,
  input  logic                      Flags_Clear_SI,
  output logic [2:0]                Flags_DO
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state_q;
  logic   prio_q;
  logic   free;
  logic   grant_a;
  logic   grant_m;
  logic   grant;

  assign Res_Valid_SO = (state_q == FULL);
  assign free    = ~Res_Valid_SO | Res_Ready_SI;
  assign grant_a = free & A_Valid_SI & (~M_Valid_SI | ~prio_q);
  assign grant_m = free & M_Valid_SI & (~A_Valid_SI | prio_q);
  assign grant   = grant_a | grant_m;

  assign A_Ready_SO = grant_a;
  assign M_Ready_SO = grant_m;

  always_comb begin
    Norm_Mant_DO = '0;
    Norm_Exp_DO  = '0;
    Norm_Sign_DO = 1'b0;
    Norm_RM_SO   = '0;
    Norm_OP_SO   = '0;
    unique case (1'b1)
      grant_a: begin
        Norm_Mant_DO = A_Mant_DI;
        Norm_Exp_DO  = A_Exp_DI;
        Norm_Sign_DO = A_Sign_DI;
        Norm_RM_SO   = A_RM_SI;
        Norm_OP_SO   = A_OP_SI;
      end
      grant_m: begin
        Norm_Mant_DO = M_Mant_DI;
        Norm_Exp_DO  = M_Exp_DI;
        Norm_Sign_DO = M_Sign_DI;
        Norm_RM_SO   = M_RM_SI;
        Norm_OP_SO   = M_OP_SI;
      end
      default: ;
    endcase
  end

  // Priority always passes to whichever side was not just served.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q        <= EMPTY;
      prio_q         <= 1'b0;
      Res_Tag_SO     <= 1'b0;
      Res_Mant_DO    <= '0;
      Res_Exp_DO     <= '0;
      Res_Sign_DO    <= 1'b0;
      Res_Rounded_SO <= 1'b0;
      Res_OF_SO      <= 1'b0;
      Res_UF_SO      <= 1'b0;
    end else if (grant) begin
      state_q        <= FULL;
      prio_q         <= grant_a;
      Res_Tag_SO     <= grant_m;
      Res_Mant_DO    <= Norm_Mant_res_DI;
      Res_Exp_DO     <= Norm_Exp_res_DI;
      Res_Sign_DO    <= Norm_Sign_DO;
      Res_Rounded_SO <= Norm_Rounded_SI;
      Res_OF_SO      <= Norm_OF_SI;
      Res_UF_SO      <= Norm_UF_SI;
    end else if (Res_Ready_SI) begin
      state_q <= EMPTY;
    end
  end

`ifdef FPU_NORM_ARB_FLAGS_EN
  logic [2:0] flags_q;
  logic [2:0] flags_set;

  assign flags_set = grant ? {Norm_OF_SI, Norm_UF_SI, Norm_Rounded_SI}
                           : 3'b000;

  // A same-cycle event survives the clear.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= (Flags_Clear_SI ? 3'b000 : flags_q) | flags_set;
    end
  end

  assign Flags_DO = flags_q;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = Flags_Clear_SI;
  assign Flags_DO = 3'b000;
`endif

endmodule

// File: tb/tb_fpu_norm_arb.sv
// Scoreboard bench for fpu_norm_arb with a behavioural normalizer
// and a transaction-level arbitration model.
module tb_fpu_norm_arb;

  typedef struct packed {
    logic        tag;
    logic [23:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        rnd;
    logic        of;
    logic        uf;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, m_valid, m_ready;
  logic [47:0] a_mant, m_mant, n_mant;
  logic [9:0]  a_exp, m_exp, n_exp;
  logic        a_sign, m_sign, n_sign;
  logic [2:0]  a_rm, m_rm, n_rm;
  logic [3:0]  a_op, m_op, n_op;
  logic [23:0] nr_mant;
  logic [7:0]  nr_exp;
  logic        nr_rnd, nr_of, nr_uf;
  logic        res_valid, res_ready, res_tag, res_sign;
  logic [23:0] res_mant;
  logic [7:0]  res_exp;
  logic        res_rnd, res_of, res_uf;
  logic        flags_clr;
  logic [2:0]  flags;

  int errors = 0;
  int checks = 0;

  item_t sb[$];
  logic       m_full;
  logic       m_next_m;
  logic [2:0] m_flags;

  always #5 clk = ~clk;

  fpu_norm_arb dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .A_Valid_SI(a_valid), .A_Ready_SO(a_ready),
    .A_Mant_DI(a_mant), .A_Exp_DI(a_exp), .A_Sign_DI(a_sign),
    .A_RM_SI(a_rm), .A_OP_SI(a_op),
    .M_Valid_SI(m_valid), .M_Ready_SO(m_ready),
    .M_Mant_DI(m_mant), .M_Exp_DI(m_exp), .M_Sign_DI(m_sign),
    .M_RM_SI(m_rm), .M_OP_SI(m_op),
    .Norm_Mant_DO(n_mant), .Norm_Exp_DO(n_exp),
    .Norm_Sign_DO(n_sign), .Norm_RM_SO(n_rm), .Norm_OP_SO(n_op),
    .Norm_Mant_res_DI(nr_mant), .Norm_Exp_res_DI(nr_exp),
    .Norm_Rounded_SI(nr_rnd), .Norm_OF_SI(nr_of), .Norm_UF_SI(nr_uf),
    .Res_Valid_SO(res_valid), .Res_Ready_SI(res_ready),
    .Res_Tag_SO(res_tag), .Res_Mant_DO(res_mant),
    .Res_Exp_DO(res_exp), .Res_Sign_DO(res_sign),
    .Res_Rounded_SO(res_rnd), .Res_OF_SO(res_of), .Res_UF_SO(res_uf),
    .Flags_Clear_SI(flags_clr), .Flags_DO(flags)
  );

  function automatic item_t norm_fn(
    input logic [47:0] m, input logic [9:0] e, input logic s,
    input logic [2:0] rm, input logic [3:0] op, input logic tag);
    item_t r;
    r.tag  = tag;
    r.mant = {1'b1, m[46:24]} ^ {14'b0, e};
    r.exp  = e[7:0] + {5'b0, rm};
    r.sign = s;
    r.rnd  = m[0] ^ op[0];
    r.of   = (e[2:0] == 3'd7);
    r.uf   = (e[5:3] == 3'd0);
    return r;
  endfunction

  // Behavioural stand-in for the shared normalizer.
  item_t nr;
  always_comb begin
    nr      = norm_fn(n_mant, n_exp, n_sign, n_rm, n_op, 1'b0);
    nr_mant = nr.mant;
    nr_exp  = nr.exp;
    nr_rnd  = nr.rnd;
    nr_of   = nr.of;
    nr_uf   = nr.uf;
  end

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic randomize_ops();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    a_mant = r[47:0];
    r = {$urandom(), $urandom()};
    m_mant = r[47:0];
    a_exp = 10'($urandom()); m_exp = 10'($urandom());
    a_sign = 1'($urandom()); m_sign = 1'($urandom());
    a_rm = 3'($urandom()); m_rm = 3'($urandom());
    a_op = 4'($urandom()); m_op = 4'($urandom());
  endtask

  // One cycle: drive at the falling edge, predict, then wait a cycle.
  task automatic cycle(input logic av, input logic mv,
                       input logic rdy, input logic clr);
    logic  free, ga, gm;
    item_t e;
    randomize_ops();
    a_valid = av; m_valid = mv; res_ready = rdy; flags_clr = clr;
    #1;
    chk("flags", 64'(flags), 64'(m_flags));
    free = !m_full || rdy;
    ga = free && av && (!mv || !m_next_m);
    gm = free && mv && (!av || m_next_m);
    chk("a_ready", 64'(a_ready), 64'(ga));
    chk("m_ready", 64'(m_ready), 64'(gm));
    if (ga) e = norm_fn(a_mant, a_exp, a_sign, a_rm, a_op, 1'b0);
    if (gm) e = norm_fn(m_mant, m_exp, m_sign, m_rm, m_op, 1'b1);
    chk("norm_mant", 64'(n_mant),
        64'(ga ? a_mant : (gm ? m_mant : 48'h0)));
`ifdef FPU_NORM_ARB_FLAGS_EN
    m_flags = (clr ? 3'b000 : m_flags) |
              ((ga || gm) ? {e.of, e.uf, e.rnd} : 3'b000);
`endif
    if (ga || gm) begin
      sb.push_back(e);
      m_next_m = ga;
      m_full = 1'b1;
    end else if (rdy) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", 64'(res_valid), 64'h0);
    chk("rst_tag", 64'(res_tag), 64'h0);
    chk("rst_mant", 64'(res_mant), 64'h0);
    chk("rst_exp", 64'(res_exp), 64'h0);
    chk("rst_stat", 64'({res_sign, res_rnd, res_of, res_uf}), 64'h0);
    chk("rst_flags", 64'(flags), 64'h0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_full = 1'b0;
    m_next_m = 1'b0;
    m_flags = 3'b000;
  endtask

  // Monitor: pops and compares on every result handshake.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_result: tag %0d mant %0h",
                   res_tag, res_mant);
        end else begin
          e = sb.pop_front();
          chk("res_tag", 64'(res_tag), 64'(e.tag));
          chk("res_mant", 64'(res_mant), 64'(e.mant));
          chk("res_exp", 64'(res_exp), 64'(e.exp));
          chk("res_sign", 64'(res_sign), 64'(e.sign));
          chk("res_stat", 64'({res_rnd, res_of, res_uf}),
              64'({e.rnd, e.of, e.uf}));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_valid = 0; m_valid = 0; res_ready = 0; flags_clr = 0;
    randomize_ops();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    repeat (4) cycle(1, 1, 1, 0);

    cycle(1, 0, 1, 0);
    repeat (3) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0));

    cycle(1, 1, 1, 0);
    cycle(0, 1, 0, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    a_valid = 0; m_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) cycle(1, 1, 1, 0);

    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 5) == 0));

    repeat (3) cycle(0, 0, 1, 0);
    chk("sb_drained", 64'(sb.size()), 64'h0);
    chk("valid_drained", 64'(res_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_norm_arb.md
# fpu_norm_arb

Round-robin arbiter and result register that shares one `fpu_norm` normalizer/rounding instance between the add/sub datapath and the multiplier datapath of the private FPU. It takes pre-normalized operands from two requesters over valid/ready handshakes. It drives the shared normalizer combinationally, captures the normalized, rounded result into a single output register tagged with its source, and accumulates sticky exception flags for the CSR.

## Interface
- `C_MANT_PRENORM`, 48, width of pre-normalized mantissa
- `C_EXP_PRENORM`, 10, width of signed pre-normalized exponent
- `C_MANT`, 23, stored mantissa width; result mantissa is C_MANT+1 bits
- `C_EXP`, 8, result exponent width
- `C_RM`, 3, rounding-mode width
- `C_CMD`, 4, operation-code width
- `Clk_CI`  in  1  clock; the only clock
- `Rst_RI`  in  1  reset, asynchronous, active-high
- `A_Valid_SI` / `A_Ready_SO`  in/out  1  add/sub requester handshake
- `A_Mant_DI`  in  C_MANT_PRENORM  add/sub mantissa
- `A_Exp_DI`  in  C_EXP_PRENORM  add/sub exponent
- `A_Sign_DI`  in  1  add/sub sign
- `A_RM_SI`  in  C_RM  add/sub rounding mode
- `A_OP_SI`  in  C_CMD  add/sub opcode
- `M_Valid_SI`, `M_Ready_SO`, `M_Mant_DI`, `M_Exp_DI`, `M_Sign_DI`, `M_RM_SI`, `M_OP_SI`  same as `A_*`, for the multiplier requester
- `Norm_Mant_DO`, `Norm_Exp_DO`, `Norm_Sign_DO`, `Norm_RM_SO`, `Norm_OP_SO`  out  as above  operands to the shared normalizer
- `Norm_Mant_res_DI`  in  C_MANT+1  normalizer mantissa result
- `Norm_Exp_res_DI`  in  C_EXP  normalizer exponent result
- `Norm_Rounded_SI`, `Norm_OF_SI`, `Norm_UF_SI`  in  1 each  normalizer status
- `Res_Valid_SO` / `Res_Ready_SI`  out/in  1  result handshake
- `Res_Tag_SO`  out  1  result source: 0 = add/sub, 1 = mul
- `Res_Mant_DO`  out  C_MANT+1  registered result mantissa
- `Res_Exp_DO`  out  C_EXP  registered result exponent
- `Res_Sign_DO`  out  1  registered result sign
- `Res_Rounded_SO`, `Res_OF_SO`, `Res_UF_SO`  out  1 each  registered status
- `Flags_Clear_SI`  in  1  clear sticky flags
- `Flags_DO`  out  3  sticky {OF, UF, NX}

## Operation
- **Slot free:** `Free = ~Res_Valid_SO | Res_Ready_SI`.
- **Grant, no contention:** with `Free` and exactly one valid requester, that requester is granted.
- **Grant, contention:** with both requesters valid, the requester named by the priority bit `Prio_SP` (0 = A, 1 = M) is granted.
- **Priority update:** after any grant, `Prio_SP` moves to the non-granted requester.
- **Ready signals:** `X_Ready_SO = Grant_X`. Ready may depend combinationally on valid; the grant is combinational.
- **Operand mux:** `Norm_*` carries the granted requester's operands. With no grant, it carries all zeros.
- **Capture:** on a grant, the output register loads `Norm_*_res`/status, the sign of the granted operand, and the tag. `Res_Valid_SO` is then 1.
- **Drain:** a handshake (`Res_Valid_SO & Res_Ready_SI`) with no new grant sets `Res_Valid_SO` to 0.
- **Stall:** while `Res_Valid_SO & ~Res_Ready_SI`, all `Res_*` outputs hold stable and both readies are 0.
- **State machine:** `EMPTY` ↔ `FULL`, encoded by `Res_Valid_SO`.
  - `EMPTY` → `FULL` on a grant.
  - `FULL` stays `FULL` on a stall, or on handshake plus grant.
  - `FULL` → `EMPTY` on handshake with no grant.

## Timing
- Reset value of every output register is 0: `Res_Valid_SO`, `Res_Tag_SO`, `Res_Mant_DO`, `Res_Exp_DO`, `Res_Sign_DO`, all `Res_*` status bits, `Prio_SP`, `Flags_DO`.
- Latency: accept at edge N → `Res_Valid_SO` = 1 after edge N.
- Throughput: one result per cycle while `Res_Ready_SI` = 1.
- The normalizer is purely combinational. Its full path, from requester operands through the normalizer to the result register, completes in one cycle.
- Reset asserted mid-operation: a pending result is discarded and no handshake is generated.
- After reset release, the first contended grant goes to A.
- Simultaneous events:
  - A result handshake and a new grant in the same cycle give back-to-back results with no bubble.
  - A flag clear and a flag set in the same cycle: the set wins (the new event is kept).

## Configuration
- `FPU_NORM_ARB_FLAGS_EN` defined:
  - On every capture, `Flags_DO |= {Norm_OF_SI, Norm_UF_SI, Norm_Rounded_SI}`.
  - `Flags_Clear_SI` zeroes the flags at the next edge, except for bits set in that same cycle.
- Not defined:
  - `Flags_DO` is tied to 3'b000 and `Flags_Clear_SI` is ignored.
  - The ports remain present.

## Test plan
- **A alone:** `A_Valid_SI`=1, `Res_Ready_SI`=1, normalizer returns mant 0x800000, exp 0x7F.
  - → `A_Ready_SO`=1 that cycle.
  - → next cycle `Res_Valid_SO`=1, tag 0, mant 0x800000, exp 0x7F.
- **Contention:** A and M both valid for 4 cycles, `Res_Ready_SI`=1.
  - → grants A, M, A, M; tags 0, 1, 0, 1 on consecutive cycles.
- **Backpressure:** result held, `Res_Ready_SI`=0 for 3 cycles, M valid.
  - → `M_Ready_SO`=0 throughout; `Res_*` stable.
  - → on ready=1, the M grant happens the same cycle, with no bubble.
- **Flags:** captures with OF=1, then a capture with Rounded=1.
  - → `Flags_DO`=3'b101.
  - → clear asserted together with a UF capture gives 3'b010.
  - → without `FPU_NORM_ARB_FLAGS_EN`, `Flags_DO` stays 0.
- **Reset mid-stream:** assert `Rst_RI` while `Res_Valid_SO`=1.
  - → all outputs 0 immediately.
  - → the next contended grant goes to A.
